// File: rtl/regs_arbiter.sv
// rtl/regs_arbiter.sv - two-requester round-robin arbiter in front of a register file, with software clear
//
// Purpose:
//   Grants at most one of two requesters per cycle onto a register file with
//   two registered read ports and one write port. A granted request presents
//   its read indices to the file in the grant cycle; the read response is
//   returned one cycle later on rsp_valid/rsp_data_a/rsp_data_b. A software
//   clear walks every register index writing zero, one index per cycle, while
//   all requesters are held off.
//
// Optional feature (macro REGS_ARBITER_BYPASS_EN):
//   When defined, a grant whose read index equals its own write index (with
//   req_write set) returns the written data instead of the file's pre-write value.
//
// Ports:
//   clk, rst                      clock; synchronous active-high reset
//   req_valid[1:0], req_ready[1:0] per-requester handshake, bit i = requester i
//   req_write[1:0]                requester i also writes when set
//   req_idx_a/b/w[2*CB-1:0]       per-requester read A/B and write index, slice [i*CB +: CB]
//   req_data[2*WORD_SIZE-1:0]     per-requester write data, slice [i*WORD_SIZE +: WORD_SIZE]
//   rsp_valid[1:0], rsp_data_a/b  read response, one cycle after the grant, no backpressure
//   rf_*                          register file write port and registered read ports
//   clear_start, clear_busy       software clear request / clear in progress

`timescale 1ns/1ps

module regs_arbiter #(
    parameter int WORD_SIZE = 16,
    parameter int COUNT     = 32,
    parameter int CB        = $clog2(COUNT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_write,
    input  logic [2*CB-1:0]        req_idx_a,
    input  logic [2*CB-1:0]        req_idx_b,
    input  logic [2*CB-1:0]        req_idx_w,
    input  logic [2*WORD_SIZE-1:0] req_data,
    output logic [1:0]             rsp_valid,
    output logic [WORD_SIZE-1:0]   rsp_data_a,
    output logic [WORD_SIZE-1:0]   rsp_data_b,
    output logic [WORD_SIZE-1:0]   rf_data_in,
    output logic [CB-1:0]          rf_idx_write,
    output logic                   rf_en_write,
    output logic [CB-1:0]          rf_idx_out_a,
    output logic [CB-1:0]          rf_idx_out_b,
    input  logic [WORD_SIZE-1:0]   rf_data_out_a,
    input  logic [WORD_SIZE-1:0]   rf_data_out_b,
    input  logic                   clear_start,
    output logic                   clear_busy
);

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;

    // rr names the requester that wins when both are valid.
    logic                  rr;
    logic [CB-1:0]         counter;
    logic [1:0]            rsp_q;

    logic [1:0]            grant;
    logic                  granted;
    logic                  win;

    logic [CB-1:0]         sel_idx_a;
    logic [CB-1:0]         sel_idx_b;
    logic [CB-1:0]         sel_idx_w;
    logic [WORD_SIZE-1:0]  sel_data;
    logic                  sel_write;

    logic [WORD_SIZE-1:0]  read_a;
    logic [WORD_SIZE-1:0]  read_b;

    // ------------------------------------------------------------------
    // Arbitration: a requester wins if it is valid and either the other
    // is idle or it holds the round-robin priority. No grants in CLEAR or
    // while reset is asserted.
    // ------------------------------------------------------------------
    always_comb begin
        grant = 2'b00;
        if (!rst && state == ARB) begin
            if (req_valid[0] && (!req_valid[1] || !rr)) begin
                grant = 2'b01;
            end else if (req_valid[1]) begin
                grant = 2'b10;
            end
        end
    end

    assign granted = |grant;
    assign win     = grant[1];

    // Winner's request fields; selection defaults to requester 0 when idle.
    assign sel_idx_a = win ? req_idx_a[CB +: CB] : req_idx_a[0 +: CB];
    assign sel_idx_b = win ? req_idx_b[CB +: CB] : req_idx_b[0 +: CB];
    assign sel_idx_w = win ? req_idx_w[CB +: CB] : req_idx_w[0 +: CB];
    assign sel_data  = win ? req_data[WORD_SIZE +: WORD_SIZE] : req_data[0 +: WORD_SIZE];
    assign sel_write = win ? req_write[1] : req_write[0];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. clear_start is only looked at in ARB, so a request
    // arriving during CLEAR is dropped rather than restarting the sweep.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ARB: begin
                if (clear_start) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                if (counter == CB'(COUNT - 1)) begin
                    state_next = ARB;
                end
            end
            default: state_next = ARB;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Reset forces the write enable low immediately so an
    // interrupted clear never lands another zero.
    // ------------------------------------------------------------------
    always_comb begin
        req_ready    = grant;
        rf_idx_out_a = sel_idx_a;
        rf_idx_out_b = sel_idx_b;
        rf_en_write  = 1'b0;
        rf_idx_write = sel_idx_w;
        rf_data_in   = sel_data;
        clear_busy   = 1'b0;
        if (!rst) begin
            if (state == CLEAR) begin
                clear_busy   = 1'b1;
                rf_en_write  = 1'b1;
                rf_idx_write = counter;
                rf_data_in   = '0;
            end else begin
                rf_en_write  = granted && sel_write;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath state: priority pointer, clear counter, response pipeline.
    // The counter sits at zero in ARB so CLEAR always starts from index 0.
    // rsp_q keeps running in CLEAR, so a read granted on the entry cycle
    // still delivers its response.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rr      <= 1'b0;
            counter <= '0;
            rsp_q   <= 2'b00;
        end else begin
            if (granted) begin
                rr <= ~win;
            end
            if (state == CLEAR && state_next == CLEAR) begin
                counter <= counter + CB'(1);
            end else begin
                counter <= '0;
            end
            rsp_q <= grant;
        end
    end

`ifdef REGS_ARBITER_BYPASS_EN
    // Remember whether the response must substitute the data written in
    // the grant cycle, since the file returns the pre-write value then.
    logic                 byp_a;
    logic                 byp_b;
    logic [WORD_SIZE-1:0] byp_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            byp_a    <= 1'b0;
            byp_b    <= 1'b0;
            byp_data <= '0;
        end else begin
            byp_a    <= granted && sel_write && (sel_idx_a == sel_idx_w);
            byp_b    <= granted && sel_write && (sel_idx_b == sel_idx_w);
            byp_data <= sel_data;
        end
    end

    assign read_a = byp_a ? byp_data : rf_data_out_a;
    assign read_b = byp_b ? byp_data : rf_data_out_b;
`else
    assign read_a = rf_data_out_a;
    assign read_b = rf_data_out_b;
`endif

    // Response outputs are held at zero when no response is presented.
    assign rsp_valid  = rst ? 2'b00 : rsp_q;
    assign rsp_data_a = (|rsp_valid) ? read_a : '0;
    assign rsp_data_b = (|rsp_valid) ? read_b : '0;

endmodule
